// File: rtl/rc_filter_bank_scheduler.sv
// Time-shared RC low-pass filter bank: a single multiplier runs STEPS
// oversampled updates per channel on each audio sample, then publishes all lanes.
//
// state | meaning
// IDLE  | waiting for audio_clk_en; outputs hold
// RUN   | one state update per cycle, channel-major, step-minor
// DONE  | publish all states to out_data, pulse out_valid
module rc_filter_bank_scheduler #(
  parameter int          CHANNELS      = 4,
  parameter int          STEPS         = 8,
  parameter logic [23:0] ALPHA_DEFAULT = 24'h100000,
  parameter logic [15:0] RESET_LEVEL   = 16'h4000
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              audio_clk_en,
  input  logic [CHANNELS*16-1:0]                            in_data,
  input  logic                                              cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [23:0]                                       cfg_alpha,
  output logic [CHANNELS*16-1:0]                            out_data,
  output logic                                              out_valid,
  output logic                                              busy,
  output logic                                              overrun
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             fsm;
  logic [CH_W-1:0]    ch;
  logic [STEP_W-1:0]  step;
  logic [15:0]        st        [CHANNELS];
  logic [15:0]        snap      [CHANNELS];
  logic [23:0]        alpha_cfg [CHANNELS];
  logic [23:0]        alpha_act [CHANNELS];

  logic [15:0]        cur_st;
  logic [15:0]        cur_in;
  logic [23:0]        cur_a;
  logic signed [16:0] diff;
  logic signed [41:0] prod;
  logic signed [17:0] delta;
  logic signed [18:0] sum;
  logic [15:0]        next_st;

  // The one shared update datapath, muxed by the current channel index.
  always_comb begin
    cur_st  = st[ch];
    cur_in  = snap[ch];
    cur_a   = alpha_act[ch];
    diff    = $signed({1'b0, cur_in}) - $signed({1'b0, cur_st});
    prod    = 42'(diff) * 42'($signed({1'b0, cur_a}));
    delta   = 18'(prod >>> 24);
    sum     = $signed({3'b000, cur_st}) + 19'(delta);
    next_st = sum[15:0];
    if (sum[18])
      next_st = 16'h0000;
    else if (|sum[17:16])
      next_st = 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm       <= IDLE;
      ch        <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        st[k]                 <= RESET_LEVEL;
        snap[k]               <= RESET_LEVEL;
        alpha_cfg[k]          <= ALPHA_DEFAULT;
        alpha_act[k]          <= ALPHA_DEFAULT;
        out_data[16*k +: 16]  <= RESET_LEVEL;
      end
    end else begin
      out_valid <= 1'b0;

      // Shadow copy below reads the pre-write value, so a write on the
      // accepting edge only lands in the next frame.
      if (cfg_we && (32'(cfg_ch) < CHANNELS))
        alpha_cfg[cfg_ch] <= cfg_alpha;

      if (audio_clk_en && (fsm != IDLE))
        overrun <= 1'b1;

      case (fsm)
        IDLE: begin
          if (audio_clk_en) begin
            for (int k = 0; k < CHANNELS; k++)
              snap[k] <= in_data[16*k +: 16];
            alpha_act <= alpha_cfg;
            ch        <= '0;
            step      <= '0;
            busy      <= 1'b1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          st[ch] <= next_st;
          if (step == STEP_W'(STEPS - 1)) begin
            step <= '0;
            if (ch == CH_W'(CHANNELS - 1))
              fsm <= DONE;
            else
              ch <= ch + 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          for (int k = 0; k < CHANNELS; k++)
            out_data[16*k +: 16] <= st[k];
          out_valid <= 1'b1;
          busy      <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_filter_bank_scheduler.sv
// Directed bench for rc_filter_bank_scheduler: table of frames with
// hand-computed outputs, plus reset, overrun and config-timing sequences.
module tb_rc_filter_bank_scheduler;

  localparam int CH = 3;
  localparam int ST = 4;
  localparam int N  = CH * ST;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          audio_clk_en = 1'b0;
  logic [47:0]   in_data = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [23:0]   cfg_alpha = '0;
  logic [47:0]   out_data;
  logic          out_valid;
  logic          busy;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  rc_filter_bank_scheduler #(
    .CHANNELS(CH),
    .STEPS(ST),
    .ALPHA_DEFAULT(24'h100000),
    .RESET_LEVEL(16'h4000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .audio_clk_en(audio_clk_en),
    .in_data(in_data),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_alpha(cfg_alpha),
    .out_data(out_data),
    .out_valid(out_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] alpha;  // {ch2, ch1, ch0}
    logic [47:0] din;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_alpha(input logic [1:0] ch, input logic [23:0] a);
    cfg_we = 1'b1; cfg_ch = ch; cfg_alpha = a;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Starts a frame at the next edge (E0). extra_edge/cfg_edge give the edge
  // index of a second strobe / cfg write (-1 = none; cfg_edge 0 = same as E0).
  task automatic run_frame(input string name, input logic [47:0] din, input logic [47:0] exp,
                           input int extra_edge, input int cfg_edge,
                           input logic [1:0] c_ch, input logic [23:0] c_a);
    int busy_n  = 0;
    int valid_n = 0;
    int valid_k = -1;
    in_data = din; audio_clk_en = 1'b1;
    cfg_we = (cfg_edge == 0); cfg_ch = c_ch; cfg_alpha = c_a;
    for (int k = 0; k <= N + 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) in_data = ~din;
      if (busy) busy_n++;
      if (out_valid) begin
        valid_n++;
        if (valid_k < 0) valid_k = k;
      end
      audio_clk_en = (extra_edge == k + 1);
      cfg_we       = (cfg_edge == k + 1);
    end
    check({name, " busy_cycles"}, 64'(busy_n), 64'(N + 1));
    check({name, " valid_edge"}, 64'(valid_k), 64'(N + 1));
    check({name, " valid_count"}, 64'(valid_n), 64'd1);
    for (int c = 0; c < CH; c++)
      check($sformatf("%s out_ch%0d", name, c), 64'(out_data[16*c +: 16]), 64'(exp[16*c +: 16]));
  endtask

  task automatic count_idle(input string name, input int cycles);
    int v = 0;
    int b = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (out_valid) v++;
      if (busy) b++;
    end
    check({name, " no_valid"}, 64'(v), 64'd0);
    check({name, " no_busy"}, 64'(b), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{alpha: {24'h100000, 24'h100000, 24'h800000},
                din:   {16'h4000, 16'h4000, 16'hC000},
                exp:   {16'h4000, 16'h4000, 16'hB800}};
    vecs[1] = '{alpha: {24'h000000, 24'h800000, 24'h800000},
                din:   {16'hFFFF, 16'h0000, 16'hB800},
                exp:   {16'h4000, 16'h0400, 16'hB800}};
    vecs[2] = '{alpha: {24'hFFFFFF, 24'h800000, 24'h800000},
                din:   {16'h0000, 16'h0400, 16'hB800},
                exp:   {16'h0000, 16'h0400, 16'hB800}};
    vecs[3] = '{alpha: {24'hFFFFFF, 24'h800000, 24'h800000},
                din:   {16'hFFFF, 16'h0400, 16'hB800},
                exp:   {16'hFFFE, 16'h0400, 16'hB800}};
    vecs[4] = '{alpha: {24'hFFFFFF, 24'h100000, 24'h800000},
                din:   {16'hFFFF, 16'hFFFF, 16'h0000},
                exp:   {16'hFFFE, 16'h3D54, 16'h0B80}};

    do_reset();
    check("reset out_data", 64'(out_data), 64'h4000_4000_4000);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset overrun", 64'(overrun), 64'd0);
    count_idle("idle", 10);

    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < CH; c++)
        write_alpha(2'(c), vecs[i].alpha[24*c +: 24]);
      run_frame($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp, -1, -1, 2'd0, 24'h0);
    end
    check("no overrun after spaced frames", 64'(overrun), 64'd0);

    // Reset in the middle of a frame.
    in_data = {16'h4000, 16'h4000, 16'hC000};
    audio_clk_en = 1'b1;
    @(posedge clk); #1 audio_clk_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    check("midreset out_data", 64'(out_data), 64'h4000_4000_4000);
    count_idle("midreset", 20);

    // Overrun: second strobe three cycles after the first.
    write_alpha(2'd0, 24'h800000);
    run_frame("ovr", {16'h4000, 16'h4000, 16'hC000}, {16'h4000, 16'h4000, 16'hB800}, 3, -1, 2'd0, 24'h0);
    check("overrun set", 64'(overrun), 64'd1);
    run_frame("post_ovr", {16'h4000, 16'h4000, 16'hB800}, {16'h4000, 16'h4000, 16'hB800}, -1, -1, 2'd0, 24'h0);
    check("overrun sticky", 64'(overrun), 64'd1);

    // Config timing.
    do_reset();
    check("reset clears overrun", 64'(overrun), 64'd0);
    write_alpha(2'd3, 24'h000000);
    run_frame("cfg_mid", {16'h4000, 16'h4000, 16'hC000}, {16'h4000, 16'h4000, 16'h5D1F}, -1, 5, 2'd0, 24'h800000);
    run_frame("cfg_next", {16'h4000, 16'h4000, 16'hC000}, {16'h4000, 16'h4000, 16'hB9D1}, -1, 0, 2'd0, 24'h000000);
    run_frame("cfg_same_edge", {16'h4000, 16'h4000, 16'hC000}, {16'h4000, 16'h4000, 16'hB9D1}, -1, -1, 2'd0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit reached");
    $fatal(1, "timeout");
  end

endmodule
